// File: rtl/ex_muldiv_ctrl_if.sv
// Handshake and result bundle between EX control (master) and the mul/div sequencer (slave).
interface ex_muldiv_ctrl_if #(
    parameter int unsigned NB_DATA = 16,
    parameter int unsigned NB_OP   = 2
);
    logic               i_start;
    logic [NB_OP-1:0]   i_op;
    logic [NB_DATA-1:0] i_operand_a;
    logic [NB_DATA-1:0] i_operand_b;
    logic               i_flush;
    logic               o_stall;
    logic               o_busy;
    logic               o_done;
    logic               o_div_by_zero;
    logic [NB_DATA-1:0] o_hi;
    logic [NB_DATA-1:0] o_lo;

    modport master (
        output i_start, i_op, i_operand_a, i_operand_b, i_flush,
        input  o_stall, o_busy, o_done, o_div_by_zero, o_hi, o_lo
    );

    modport slave (
        input  i_start, i_op, i_operand_a, i_operand_b, i_flush,
        output o_stall, o_busy, o_done, o_div_by_zero, o_hi, o_lo
    );
endinterface

// File: rtl/ex_muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer for the EX stage.
// Iterative shift-add multiply (LSB first) and restoring divide (MSB first) on
// operand magnitudes, sign fix-up at the end, HI/LO loaded when the FIX step completes.
// Optional macro MULDIV_EARLY_EXIT_EN: multiplies leave ITER as soon as the remaining
// multiplier bits are zero (at least one ITER cycle); divide latency is unchanged.
module ex_muldiv_ctrl #(
    parameter int unsigned NB_DATA = 16,
    parameter int unsigned NB_OP   = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    ex_muldiv_ctrl_if.slave bus
);

    localparam int unsigned NB_PROD = 2 * NB_DATA;
    localparam int unsigned NB_CNT  = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
    localparam int unsigned MSB     = NB_DATA - 1;
    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(NB_DATA - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_ITER,
        ST_FIX,
        ST_DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    // Latched request
    logic [NB_OP-1:0]   op_q;
    logic [NB_DATA-1:0] opa_q;
    logic [NB_DATA-1:0] opb_q;

    // Iteration datapath
    logic [NB_DATA-1:0] mag_b_q;    // divisor magnitude
    logic [NB_DATA-1:0] shf_q;      // mul: remaining multiplier, div: dividend -> quotient
    logic [NB_PROD-1:0] acc_q;      // mul: product accumulator, div: partial remainder (low half)
    logic [NB_PROD-1:0] mcand_q;    // mul: multiplicand shifted to current bit weight
    logic               neg_lo_q;   // negate product / quotient
    logic               neg_hi_q;   // negate remainder
    logic [NB_CNT-1:0]  cnt_q;

    // Registered outputs
    logic               done_q;
    logic               busy_q;
    logic               dbz_q;
    logic [NB_DATA-1:0] hi_q;
    logic [NB_DATA-1:0] lo_q;

    // FSM strobes
    logic ld_op;
    logic ld_res;
    logic ld_dbz;
    logic stall_c;

    logic is_div_c;
    logic is_signed_c;
    logic early_exit_c;

    logic [NB_DATA-1:0] mag_a_c;
    logic [NB_DATA-1:0] mag_b_c;
    logic [NB_PROD-1:0] mul_acc_c;
    logic [NB_DATA-1:0] mul_shf_c;
    logic [NB_DATA:0]   div_trial_c;
    logic [NB_DATA:0]   div_diff_c;
    logic               div_ok_c;
    logic [NB_DATA-1:0] div_rem_c;
    logic [NB_PROD-1:0] prod_c;
    logic [NB_DATA-1:0] quo_c;
    logic [NB_DATA-1:0] rem_c;
    logic [NB_DATA-1:0] res_hi_c;
    logic [NB_DATA-1:0] res_lo_c;

    // Operation decode: bit 1 selects divide, bit 0 selects signed
    assign is_div_c    = op_q[1];
    assign is_signed_c = op_q[0];

    // Operand magnitudes for signed ops (the most negative value maps to itself as unsigned)
    assign mag_a_c = (is_signed_c && opa_q[MSB]) ? (NB_DATA'(0) - opa_q) : opa_q;
    assign mag_b_c = (is_signed_c && opb_q[MSB]) ? (NB_DATA'(0) - opb_q) : opb_q;

    // One shift-add multiply step
    assign mul_acc_c = shf_q[0] ? (acc_q + mcand_q) : acc_q;
    assign mul_shf_c = shf_q >> 1;

    // One restoring divide step: shift in next dividend bit, subtract if it fits
    assign div_trial_c = {acc_q[NB_DATA-1:0], shf_q[MSB]};
    assign div_diff_c  = div_trial_c - {1'b0, mag_b_q};
    assign div_ok_c    = ~div_diff_c[NB_DATA];
    assign div_rem_c   = div_ok_c ? div_diff_c[NB_DATA-1:0] : div_trial_c[NB_DATA-1:0];

`ifdef MULDIV_EARLY_EXIT_EN
    // Multiply finishes once no set multiplier bits remain
    assign early_exit_c = ~is_div_c && (mul_shf_c == '0);
`else
    assign early_exit_c = 1'b0;
`endif

    // Sign fix-up of the magnitude results
    assign prod_c   = neg_lo_q ? (NB_PROD'(0) - acc_q) : acc_q;
    assign quo_c    = neg_lo_q ? (NB_DATA'(0) - shf_q) : shf_q;
    assign rem_c    = neg_hi_q ? (NB_DATA'(0) - acc_q[NB_DATA-1:0]) : acc_q[NB_DATA-1:0];
    assign res_hi_c = is_div_c ? rem_c : prod_c[NB_PROD-1:NB_DATA];
    assign res_lo_c = is_div_c ? quo_c : prod_c[NB_DATA-1:0];

    // State register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control strobes; flush always wins over start and progress
    always_comb begin
        state_d = state_q;
        ld_op   = 1'b0;
        ld_res  = 1'b0;
        ld_dbz  = 1'b0;
        stall_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                stall_c = bus.i_start;
                if (bus.i_start && !bus.i_flush) begin
                    ld_op   = 1'b1;
                    state_d = ST_PREP;
                end
            end
            ST_PREP: begin
                stall_c = 1'b1;
                if (bus.i_flush) begin
                    state_d = ST_IDLE;
                end else if (is_div_c && (opb_q == '0)) begin
                    ld_dbz  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ITER;
                end
            end
            ST_ITER: begin
                stall_c = 1'b1;
                if (bus.i_flush) begin
                    state_d = ST_IDLE;
                end else if ((cnt_q == CNT_LAST) || early_exit_c) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                stall_c = 1'b1;
                if (bus.i_flush) begin
                    state_d = ST_IDLE;
                end else begin
                    ld_res  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Request latch, operand preparation and per-cycle iteration
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            op_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            mag_b_q  <= '0;
            shf_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            if (ld_op) begin
                op_q  <= bus.i_op;
                opa_q <= bus.i_operand_a;
                opb_q <= bus.i_operand_b;
            end
            case (state_q)
                ST_PREP: begin
                    cnt_q    <= '0;
                    neg_lo_q <= is_signed_c & (opa_q[MSB] ^ opb_q[MSB]);
                    neg_hi_q <= is_signed_c & opa_q[MSB];
                    mag_b_q  <= mag_b_c;
                    shf_q    <= is_div_c ? mag_a_c : mag_b_c;
                    acc_q    <= '0;
                    mcand_q  <= NB_PROD'(mag_a_c);
                end
                ST_ITER: begin
                    cnt_q <= cnt_q + NB_CNT'(1);
                    if (is_div_c) begin
                        acc_q <= NB_PROD'(div_rem_c);
                        shf_q <= {shf_q[NB_DATA-2:0], div_ok_c};
                    end else begin
                        acc_q   <= mul_acc_c;
                        mcand_q <= mcand_q << 1;
                        shf_q   <= mul_shf_c;
                    end
                end
                default: ;
            endcase
        end
    end

    // Result and status outputs
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            done_q <= 1'b0;
            busy_q <= 1'b0;
            dbz_q  <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            done_q <= ld_res | ld_dbz;
            busy_q <= (state_d != ST_IDLE);
            if (ld_op) begin
                dbz_q <= 1'b0;
            end else if (ld_dbz) begin
                dbz_q <= 1'b1;
            end
            if (ld_res) begin
                hi_q <= res_hi_c;
                lo_q <= res_lo_c;
            end else if (ld_dbz) begin
                hi_q <= opa_q;
                lo_q <= '1;
            end
        end
    end

    // Stall is combinational so the requesting instruction freezes in its own cycle
    assign bus.o_stall       = i_rst & stall_c;
    assign bus.o_busy        = busy_q;
    assign bus.o_done        = done_q;
    assign bus.o_div_by_zero = dbz_q;
    assign bus.o_hi          = hi_q;
    assign bus.o_lo          = lo_q;

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Scoreboard bench for ex_muldiv_ctrl: driver pushes model results, monitor pops on o_done.
module tb_ex_muldiv_ctrl;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_fail;

    typedef struct {
        logic [15:0] hi;
        logic [15:0] lo;
        logic        dbz;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] last_hi;
    logic [15:0] last_lo;

    ex_muldiv_ctrl_if #(.NB_DATA(16), .NB_OP(2)) bus ();

    ex_muldiv_ctrl #(.NB_DATA(16), .NB_OP(2)) dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the architectural operation
    function automatic exp_t model(input logic [1:0] op, input logic [15:0] a,
                                   input logic [15:0] b, input int c0);
        exp_t   e;
        longint va, vb, p, q, r, mb;
        int     nbits;
        e.dbz = 1'b0;
        va = op[0] ? longint'($signed(a)) : longint'(a);
        vb = op[0] ? longint'($signed(b)) : longint'(b);
        if (!op[1]) begin
            p    = va * vb;
            e.hi = p[31:16];
            e.lo = p[15:0];
            mb    = (vb < 0) ? -vb : vb;
            nbits = 0;
            while (mb != 0) begin
                nbits++;
                mb = mb >> 1;
            end
`ifdef MULDIV_EARLY_EXIT_EN
            e.cyc = c0 + ((nbits < 1) ? 1 : nbits) + 3;
`else
            e.cyc = c0 + 19;
`endif
        end else if (b == 16'h0000) begin
            e.hi  = a;
            e.lo  = 16'hFFFF;
            e.dbz = 1'b1;
            e.cyc = c0 + 2;
        end else begin
            q     = va / vb;
            r     = va % vb;
            e.hi  = r[15:0];
            e.lo  = q[15:0];
            e.cyc = c0 + 19;
        end
        return e;
    endfunction

    task automatic drive_start(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        bus.i_start     = 1'b1;
        bus.i_op        = op;
        bus.i_operand_a = a;
        bus.i_operand_b = b;
        #1;
        check("stall_on_start", 32'(bus.o_stall), 32'd1);
        @(negedge clk); #2;
        bus.i_start = 1'b0;
    endtask

    task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        e = model(op, a, b, cyc);
        sb_q.push_back(e);
        last_hi = e.hi;
        last_lo = e.lo;
        drive_start(op, a, b);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clk); #2;
            n++;
        end
        check("drain_timeout", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
        @(negedge clk); #2;
    endtask

    // Monitor: every o_done pulse must match the oldest expected result
    always @(negedge clk) begin
        if (rst_n && bus.o_done) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: o_done high with nothing outstanding (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("done_cycle", 32'(cyc), 32'(e.cyc));
                check("hi", 32'(bus.o_hi), 32'(e.hi));
                check("lo", 32'(bus.o_lo), 32'(e.lo));
                check("div_by_zero", 32'(bus.o_div_by_zero), 32'(e.dbz));
                check("stall_in_done", 32'(bus.o_stall), 32'd0);
                check("busy_in_done", 32'(bus.o_busy), 32'd1);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_hi"}, 32'(bus.o_hi), 32'd0);
        check({tag, "_lo"}, 32'(bus.o_lo), 32'd0);
        check({tag, "_done"}, 32'(bus.o_done), 32'd0);
        check({tag, "_busy"}, 32'(bus.o_busy), 32'd0);
        check({tag, "_dbz"}, 32'(bus.o_div_by_zero), 32'd0);
        check({tag, "_stall"}, 32'(bus.o_stall), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k0;
        int          r;
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;

        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        rst_n    = 1'b0;
        bus.i_start     = 1'b0;
        bus.i_op        = 2'b00;
        bus.i_operand_a = 16'h0000;
        bus.i_operand_b = 16'h0000;
        bus.i_flush     = 1'b0;
        last_hi = 16'h0000;
        last_lo = 16'h0000;

        repeat (3) @(negedge clk);
        #2;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk); #2;

        // MULTU with stall window check
        k0 = cyc;
        issue(2'b00, 16'h1234, 16'h0010);
        while (cyc < k0 + 18) begin
            @(negedge clk); #2;
        end
        check("stall_last_cycle", 32'(bus.o_stall), 32'd1);
        check("busy_last_cycle", 32'(bus.o_busy), 32'd1);
        wait_drain();

        // Directed vectors
        issue(2'b01, 16'hFFFD, 16'h0007); wait_drain();
        issue(2'b10, 16'd100,  16'd7);    wait_drain();
        issue(2'b11, 16'hFFF9, 16'h0002); wait_drain();
        issue(2'b11, 16'h8000, 16'hFFFF); wait_drain();
        issue(2'b10, 16'h0005, 16'h0000); wait_drain();
        check("dbz_holds", 32'(bus.o_div_by_zero), 32'd1);
        issue(2'b11, 16'h7FFF, 16'h0000); wait_drain();
        issue(2'b00, 16'h1234, 16'h0003); wait_drain();
        issue(2'b00, 16'hFFFF, 16'h0000); wait_drain();
        issue(2'b01, 16'h8000, 16'h8000); wait_drain();
        issue(2'b00, 16'hFFFF, 16'hFFFF); wait_drain();

        // Flush during ITER; starts while busy are ignored
        k0 = cyc;
        drive_start(2'b00, 16'h00FF, 16'h8001);
        while (cyc < k0 + 3) begin
            @(negedge clk); #2;
        end
        bus.i_start = 1'b1; bus.i_op = 2'b10; bus.i_operand_a = 16'd9;
        @(negedge clk); #2;
        bus.i_start = 1'b1; bus.i_op = 2'b01;
        @(negedge clk); #2;
        bus.i_start = 1'b0;
        bus.i_flush = 1'b1;
        @(negedge clk); #2;
        bus.i_flush = 1'b0;
        check("flush_busy", 32'(bus.o_busy), 32'd0);
        check("flush_stall", 32'(bus.o_stall), 32'd0);
        check("flush_hi_kept", 32'(bus.o_hi), 32'(last_hi));
        check("flush_lo_kept", 32'(bus.o_lo), 32'(last_lo));
        repeat (25) @(negedge clk);
        #2;

        // Flush beats start in IDLE
        bus.i_start = 1'b1; bus.i_flush = 1'b1; bus.i_op = 2'b00;
        @(negedge clk); #2;
        bus.i_start = 1'b0; bus.i_flush = 1'b0;
        check("flush_beats_start", 32'(bus.o_busy), 32'd0);
        repeat (25) @(negedge clk);
        #2;

        // Reset in the middle of a DIV
        k0 = cyc;
        drive_start(2'b11, 16'hF123, 16'h0045);
        while (cyc < k0 + 8) begin
            @(negedge clk); #2;
        end
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        last_hi = 16'h0000;
        last_lo = 16'h0000;
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk); #2;

        // Randomized operations with corner-case bias
        for (int i = 0; i < 150; i++) begin
            r  = $urandom_range(0, 9);
            op = 2'($urandom_range(0, 3));
            a  = 16'($urandom);
            b  = 16'($urandom);
            if (r == 0) b = 16'h0000;
            if (r == 1) begin a = 16'h8000; b = 16'hFFFF; end
            if (r == 2) b = 16'($urandom_range(0, 15));
            if (r == 3) a = 16'hFFFF;
            issue(op, a, b);
            wait_drain();
        end
        repeat (5) @(negedge clk);
        #2;
        check("hold_hi", 32'(bus.o_hi), 32'(last_hi));
        check("hold_lo", 32'(bus.o_lo), 32'(last_lo));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
